mdu_ctrl: RTL

- Multi-cycle multiply/divide sequencer that sits beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from EX and latches the operands once.
- Drives the external radix-2 `div` unit through its start/annul/ready handshake and runs an internal MUL_LAT-stage multiplier.
- Stalls the pipeline until the 64-bit result is ready, then issues exactly one HILO write per instruction; all other ALU ops bypass it.

---
 rtl/mdu_ctrl_if.sv | 38 +++
 rtl/mdu_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - EX-side and divider-side signal bundle for the multiply/divide sequencer
interface mdu_ctrl_if;
    // EX stage request
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall_in;

    // external radix-2 divider handshake
    logic        div_start;
    logic        div_sign;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    // pipeline / HILO side
    logic        stall_req;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        wd_err;

    modport master (
        output op, a, b, flush, stall_in, div_result, div_ready,
        input  div_start, div_sign, div_opa, div_opb, div_annul,
               stall_req, hilo_we, hi_out, lo_out, busy, wd_err
    );

    modport slave (
        input  op, a, b, flush, stall_in, div_result, div_ready,
        output div_start, div_sign, div_opa, div_opb, div_annul,
               stall_req, hilo_we, hi_out, lo_out, busy, wd_err
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer with HILO write-back
module mdu_ctrl #(
    parameter int MUL_LAT     = 2,
    parameter int DIV_MAX_CYC = 40
) (
    input  logic       clk,
    input  logic       rst,
    mdu_ctrl_if.slave  bus
);
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam int WW = $clog2(DIV_MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_WAIT = 3'd2,
        S_DZERO    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [WW-1:0] wcnt_inc;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        sign_q, sign_d;
    logic        div_start_q, div_start_d;
    logic        div_annul_q, div_annul_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        wd_err_q, wd_err_d;
    logic        hilo_we_c;

    logic        md_op;
    logic        is_mul;
    logic [63:0] ext_a, ext_b;
    logic [63:0] prod_c;
    logic [63:0] mul_tap;

    assign md_op  = (bus.op == EXE_MULT_OP) || (bus.op == EXE_MULTU_OP) ||
                    (bus.op == EXE_DIV_OP)  || (bus.op == EXE_DIVU_OP);
    assign is_mul = (bus.op == EXE_MULT_OP) || (bus.op == EXE_MULTU_OP);
    assign wcnt_inc = wcnt_q + WW'(1);

    // Full 64-bit product of the latched operands; sign/zero extension makes one multiplier serve both forms
    always_comb begin
        ext_a  = sign_q ? {{32{opa_q[31]}}, opa_q} : {32'b0, opa_q};
        ext_b  = sign_q ? {{32{opb_q[31]}}, opb_q} : {32'b0, opb_q};
        prod_c = ext_a * ext_b;
    end

    // The HI/LO load is the last multiplier stage, so MUL_LAT-1 intermediate registers sit in front of it
    generate
        if (MUL_LAT > 1) begin : g_mul_pipe
            logic [63:0] pipe_q [MUL_LAT-1];
            logic [63:0] pipe_d [MUL_LAT-1];

            // Shift the product through the intermediate stages
            always_comb begin
                pipe_d[0] = prod_c;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Intermediate product stage registers
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign mul_tap = pipe_q[MUL_LAT-2];
        end else begin : g_mul_direct
            assign mul_tap = prod_c;
        end
    endgenerate

    // Next-state, operand latching, divider handshake and result loading
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sign_d      = sign_q;
        div_start_d = div_start_q;
        div_annul_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        wd_err_d    = wd_err_q;
        hilo_we_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (md_op && !bus.flush) begin
                    opa_d  = bus.a;
                    opb_d  = bus.b;
                    sign_d = (bus.op == EXE_MULT_OP) || (bus.op == EXE_DIV_OP);
                    if (is_mul) begin
                        state_d = S_MUL_WAIT;
                        cnt_d   = 3'(MUL_LAT - 1);
                    end else if (bus.b != 32'd0) begin
                        state_d     = S_DIV_WAIT;
                        div_start_d = 1'b1;
                        wcnt_d      = '0;
                    end else begin
                        state_d = S_DZERO;
                    end
                end
            end

            S_MUL_WAIT: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 3'd0) begin
                    hi_d    = mul_tap[63:32];
                    lo_d    = mul_tap[31:0];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_DIV_WAIT: begin
                if (bus.flush) begin
                    // A div_ready coinciding with the flush is dropped on purpose
                    state_d     = S_IDLE;
                    div_start_d = 1'b0;
                    div_annul_d = 1'b1;
                end else if (bus.div_ready) begin
                    hi_d        = bus.div_result[63:32];
                    lo_d        = bus.div_result[31:0];
                    div_start_d = 1'b0;
                    state_d     = S_DONE;
                end else if (wcnt_inc == WW'(DIV_MAX_CYC)) begin
                    wd_err_d    = 1'b1;
                    div_annul_d = 1'b1;
                    div_start_d = 1'b0;
                    hi_d        = 32'd0;
                    lo_d        = 32'd0;
                    state_d     = S_DONE;
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end

            S_DZERO: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = opa_q;
                    lo_d    = 32'hFFFF_FFFF;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (!bus.stall_in) begin
                    hilo_we_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                div_start_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sign_q      <= 1'b0;
            div_start_q <= 1'b0;
            div_annul_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            wd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sign_q      <= sign_d;
            div_start_q <= div_start_d;
            div_annul_q <= div_annul_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            wd_err_q    <= wd_err_d;
        end
    end

    assign bus.stall_req = md_op && !bus.flush && (state_q != S_DONE);
    assign bus.hilo_we   = hilo_we_c;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.div_start = div_start_q;
    assign bus.div_sign  = sign_q;
    assign bus.div_opa   = opa_q;
    assign bus.div_opb   = opb_q;
    assign bus.div_annul = div_annul_q;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
    assign bus.wd_err    = wd_err_q;
endmodule
